riscv_multicycle_controller: RTL and testbench

Main control FSM for the multicycle RV32I core. It sequences the shared datapath (one memory port, one ALU, one immediate extender) through fetch, decode, execute, memory and writeback states. Each cycle it drives the extender's immediate-format select, the ALU operand and result muxes, the write enables and the ALU operation. A `mem_ready` handshake stretches the memory states for slow memories.

---
 rtl/riscv_multicycle_controller.sv | 170 +++++++++++++++++
 tb/tb_riscv_multicycle_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences the shared
// datapath through fetch/decode/execute/memory/writeback with a mem_ready stall.
module riscv_multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic [2:0] alu_control,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     state_q, state_d;
    logic [2:0] funct_alu;
    logic       ir_w, pc_w, reg_w, mem_w, ill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // op[5] separates R-type (sub allowed) from I-type (funct7b5 is imm bit)
    always_comb begin
        case (funct3)
            3'b000:  funct_alu = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        imm_src     = '0;
        alu_src_a   = '0;
        alu_src_b   = '0;
        result_src  = '0;
        adr_src     = 1'b0;
        alu_control = ALU_ADD;
        ir_w        = 1'b0;
        pc_w        = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        ill         = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_w       = mem_ready;
                pc_w       = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECR;
                    OP_ITYP:      state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d = S_FETCH;
                        ill     = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = op[5] ? 2'b01 : 2'b00;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = funct_alu;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = funct_alu;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                imm_src   = 2'b11;
                pc_w      = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                imm_src     = 2'b10;
                alu_control = ALU_SUB;
                pc_w        = zero;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are masked by rst_n so nothing writes while reset is held low
    assign ir_write   = ir_w  & rst_n;
    assign pc_write   = pc_w  & rst_n;
    assign reg_write  = reg_w & rst_n;
    assign mem_write  = mem_w & rst_n;
    assign illegal_op = ill   & rst_n;
    assign state_o    = state_q;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Directed bench for riscv_multicycle_controller: expected per-cycle output
// vectors are queued as stimulus is driven and popped at the falling edge.
module tb_riscv_multicycle_controller;

    // {state, imm, a, b, rs, adr, ir, pc, rw, mw, alu, ill}
    typedef logic [20:0] vec_t;
    typedef struct {
        string tag;
        vec_t  v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
    logic       adr_src, ir_write, pc_write, reg_write, mem_write;
    logic [2:0] alu_control;
    logic       illegal_op;
    logic [3:0] state_o;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    riscv_multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .imm_src(imm_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_write(mem_write), .alu_control(alu_control), .illegal_op(illegal_op),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t V(input logic [3:0] st, input logic [1:0] imm, input logic [1:0] a,
                               input logic [1:0] b, input logic [1:0] rs, input logic adr,
                               input logic ir, input logic pc, input logic rw, input logic mw,
                               input logic [2:0] alu, input logic ill);
        return {st, imm, a, b, rs, adr, ir, pc, rw, mw, alu, ill};
    endfunction

    function automatic vec_t E_FETCH(input logic en);
        return V(4'd0, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, en, en, 1'b0, 1'b0, 3'b000, 1'b0);
    endfunction
    function automatic vec_t E_DEC(input logic ill);
        return V(4'd1, 2'b10, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, ill);
    endfunction
    function automatic vec_t E_MEMADR(input logic [1:0] imm);
        return V(4'd2, imm, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    endfunction
    function automatic vec_t E_MEMREAD();
        return V(4'd3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    endfunction
    function automatic vec_t E_MEMWB();
        return V(4'd4, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    endfunction
    function automatic vec_t E_MEMWR();
        return V(4'd5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    endfunction
    function automatic vec_t E_EXECR(input logic [2:0] alu);
        return V(4'd6, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, alu, 1'b0);
    endfunction
    function automatic vec_t E_ALUWB();
        return V(4'd7, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    endfunction
    function automatic vec_t E_EXECI(input logic [2:0] alu);
        return V(4'd8, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, alu, 1'b0);
    endfunction
    function automatic vec_t E_JAL();
        return V(4'd9, 2'b11, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    endfunction
    function automatic vec_t E_BEQ(input logic pc);
        return V(4'd10, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, pc, 1'b0, 1'b0, 3'b001, 1'b0);
    endfunction

    task automatic push(input string tag, input vec_t v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        vec_t obs;
        obs = {state_o, imm_src, alu_src_a, alu_src_b, result_src, adr_src, ir_write,
               pc_write, reg_write, mem_write, alu_control, illegal_op};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    // One clock cycle: drive, queue expectation, compare at negedge, advance
    task automatic cyc(input string tag, input logic z, input logic mr, input vec_t e);
        zero      = z;
        mem_ready = mr;
        push(tag, e);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_now(input string tag, input vec_t e);
        push(tag, e);
        pop_check();
    endtask

    task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input vec_t ex);
        set_instr(o, f3, f7);
        cyc({tag, "_f"}, 1'b0, 1'b1, E_FETCH(1'b1));
        cyc({tag, "_d"}, 1'b0, 1'b1, E_DEC(1'b0));
        cyc({tag, "_x"}, 1'b1, 1'b0, ex);
        cyc({tag, "_wb"}, 1'b0, 1'b0, E_ALUWB());
    endtask

    initial begin
        rst_n = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0);
        zero = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_state", 1'b0, 1'b1, E_FETCH(1'b0));
        rst_n = 1'b1;

        // lw, with mem_ready low in states that must ignore it
        cyc("lw_f",   1'b0, 1'b1, E_FETCH(1'b1));
        cyc("lw_d",   1'b1, 1'b0, E_DEC(1'b0));
        cyc("lw_adr", 1'b1, 1'b0, E_MEMADR(2'b00));
        cyc("lw_rd",  1'b0, 1'b1, E_MEMREAD());
        cyc("lw_wb",  1'b0, 1'b0, E_MEMWB());

        // sw with a fetch stall and a three-cycle write stall
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fstall", 1'b0, 1'b0, E_FETCH(1'b0));
        cyc("sw_f",      1'b0, 1'b1, E_FETCH(1'b1));
        cyc("sw_d",      1'b0, 1'b1, E_DEC(1'b0));
        cyc("sw_adr",    1'b0, 1'b1, E_MEMADR(2'b01));
        for (int i = 0; i < 3; i++) cyc("sw_wr_stall", 1'b0, 1'b0, E_MEMWR());
        cyc("sw_wr_done", 1'b0, 1'b1, E_MEMWR());

        // lw with a read stall
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc("lw2_f",      1'b0, 1'b1, E_FETCH(1'b1));
        cyc("lw2_d",      1'b0, 1'b1, E_DEC(1'b0));
        cyc("lw2_adr",    1'b0, 1'b1, E_MEMADR(2'b00));
        cyc("lw2_rstall", 1'b0, 1'b0, E_MEMREAD());
        cyc("lw2_rd",     1'b0, 1'b1, E_MEMREAD());
        cyc("lw2_wb",     1'b0, 1'b1, E_MEMWB());

        alu_instr("r_sub",  7'b0110011, 3'b000, 1'b1, E_EXECR(3'b001));
        alu_instr("i_addi", 7'b0010011, 3'b000, 1'b1, E_EXECI(3'b000));
        alu_instr("r_add",  7'b0110011, 3'b000, 1'b0, E_EXECR(3'b000));
        alu_instr("r_slt",  7'b0110011, 3'b010, 1'b0, E_EXECR(3'b101));
        alu_instr("i_ori",  7'b0010011, 3'b110, 1'b0, E_EXECI(3'b011));
        alu_instr("r_and",  7'b0110011, 3'b111, 1'b0, E_EXECR(3'b010));
        alu_instr("i_f001", 7'b0010011, 3'b001, 1'b1, E_EXECI(3'b000));

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc("jal_f",  1'b0, 1'b1, E_FETCH(1'b1));
        cyc("jal_d",  1'b0, 1'b1, E_DEC(1'b0));
        cyc("jal_x",  1'b0, 1'b0, E_JAL());
        cyc("jal_wb", 1'b0, 1'b1, E_ALUWB());

        // beq taken and not taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        cyc("beq1_f", 1'b0, 1'b1, E_FETCH(1'b1));
        cyc("beq1_d", 1'b1, 1'b1, E_DEC(1'b0));
        cyc("beq1_x", 1'b1, 1'b1, E_BEQ(1'b1));
        cyc("beq0_f", 1'b1, 1'b1, E_FETCH(1'b1));
        cyc("beq0_d", 1'b1, 1'b1, E_DEC(1'b0));
        cyc("beq0_x", 1'b0, 1'b1, E_BEQ(1'b0));

        // illegal opcodes
        set_instr(7'b0000000, 3'b000, 1'b0);
        cyc("ill0_f", 1'b0, 1'b1, E_FETCH(1'b1));
        cyc("ill0_d", 1'b0, 1'b1, E_DEC(1'b1));
        set_instr(7'b1111111, 3'b000, 1'b0);
        cyc("ill1_f", 1'b0, 1'b1, E_FETCH(1'b1));
        cyc("ill1_d", 1'b0, 1'b1, E_DEC(1'b1));

        // reset asserted mid-EXECR
        set_instr(7'b0110011, 3'b000, 1'b1);
        cyc("rst_f", 1'b0, 1'b1, E_FETCH(1'b1));
        cyc("rst_d", 1'b0, 1'b1, E_DEC(1'b0));
        zero = 1'b0;
        mem_ready = 1'b1;
        #2;
        chk_now("rst_execr", E_EXECR(3'b001));
        rst_n = 1'b0;
        #1;
        chk_now("rst_async", E_FETCH(1'b0));
        @(posedge clk);
        #1;
        chk_now("rst_hold", E_FETCH(1'b0));
        rst_n = 1'b1;
        cyc("rst_rel_f", 1'b0, 1'b1, E_FETCH(1'b1));
        cyc("rst_rel_d", 1'b0, 1'b1, E_DEC(1'b0));
        cyc("rst_rel_x", 1'b0, 1'b1, E_EXECR(3'b001));

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
